// File: rtl/smol_pkg.sv
// rtl/smol_pkg.sv - shared widths, types and operand-resolve helper for the operand-fetch slice
package smol_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;
    localparam int STALL_W    = 16;

    typedef logic [XLEN-1:0]       xlen_t;
    typedef logic [REG_ADDR_W-1:0] reg_idx_t;

    // One registered operand bundle as handed downstream.
    typedef struct packed {
        xlen_t    op1;
        xlen_t    op2;
        reg_idx_t rd;
        logic     wr_rd;
    } opbundle_t;

    // Operand priority: x0 / unused reads as zero, then the writeback bus
    // (the register file has not been written yet this cycle), then the
    // asynchronous register-file read data.
    function automatic xlen_t resolve_operand(
        input logic     use_rs,
        input reg_idx_t rs,
        input logic     wb_en,
        input reg_idx_t wb_addr,
        input xlen_t    wb_data,
        input xlen_t    rf_rdata
    );
        if (!use_rs || rs == '0) begin
            return '0;
        end else if (wb_en && wb_addr == rs) begin
            return wb_data;
        end else begin
            return rf_rdata;
        end
    endfunction

endpackage

// File: rtl/smol_opfetch_if.sv
// rtl/smol_opfetch_if.sv - decoded-instruction, register-file, writeback and operand-bundle bus
//   in_*     : decoded-instruction handshake and register fields (upstream -> fetch)
//   rf_*     : register-file read port (fetch drives enables/addresses, file returns data)
//   wb_*     : writeback bus shared with the register-file write port
//   flush    : drop the held output entry
//   out_*    : operand-bundle handshake (fetch -> downstream)
//   stall_cnt: saturating count of hazard-stall cycles
interface smol_opfetch_if;
    import smol_pkg::*;

    logic                in_valid;
    logic                in_ready;
    reg_idx_t            in_rs1;
    reg_idx_t            in_rs2;
    reg_idx_t            in_rd;
    logic                in_use_rs1;
    logic                in_use_rs2;
    logic                in_wr_rd;

    logic                rf_ren1;
    logic                rf_ren2;
    reg_idx_t            rf_raddr1;
    reg_idx_t            rf_raddr2;
    xlen_t               rf_rdata1;
    xlen_t               rf_rdata2;

    logic                wb_en;
    reg_idx_t            wb_addr;
    xlen_t               wb_data;

    logic                flush;

    logic                out_valid;
    logic                out_ready;
    xlen_t               out_op1;
    xlen_t               out_op2;
    reg_idx_t            out_rd;
    logic                out_wr_rd;

    logic [STALL_W-1:0]  stall_cnt;

    // master: the surrounding pipeline / register file side
    modport master (
        output in_valid, in_rs1, in_rs2, in_rd, in_use_rs1, in_use_rs2, in_wr_rd,
        output rf_rdata1, rf_rdata2,
        output wb_en, wb_addr, wb_data,
        output flush, out_ready,
        input  in_ready, rf_ren1, rf_ren2, rf_raddr1, rf_raddr2,
        input  out_valid, out_op1, out_op2, out_rd, out_wr_rd, stall_cnt
    );

    // slave: the operand-fetch stage
    modport slave (
        input  in_valid, in_rs1, in_rs2, in_rd, in_use_rs1, in_use_rs2, in_wr_rd,
        input  rf_rdata1, rf_rdata2,
        input  wb_en, wb_addr, wb_data,
        input  flush, out_ready,
        output in_ready, rf_ren1, rf_ren2, rf_raddr1, rf_raddr2,
        output out_valid, out_op1, out_op2, out_rd, out_wr_rd, stall_cnt
    );

endinterface

// File: rtl/smol_scoreboard.sv
// rtl/smol_scoreboard.sv - per-register busy bits with set/clear ports and RAW/WAW lookups
//   clk, rst                : clock, synchronous active-high reset
//   set_en/set_idx          : mark a destination busy on issue
//   wb_clr_en/wb_clr_idx    : clear on writeback
//   fl_clr_en/fl_clr_idx    : clear when a held entry is flushed
//   raw_idx1/2 -> raw_busy1/2 : RAW lookup port (two source registers)
//   waw_idx    -> waw_busy    : WAW lookup port (destination register)
module smol_scoreboard
    import smol_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    input  logic     set_en,
    input  reg_idx_t set_idx,
    input  logic     wb_clr_en,
    input  reg_idx_t wb_clr_idx,
    input  logic     fl_clr_en,
    input  reg_idx_t fl_clr_idx,
    input  reg_idx_t raw_idx1,
    input  reg_idx_t raw_idx2,
    output logic     raw_busy1,
    output logic     raw_busy2,
    input  reg_idx_t waw_idx,
    output logic     waw_busy
);

    logic [NUM_REGS-1:0] busy;
    logic [NUM_REGS-1:0] busy_d;

    // Clears first so a same-index set overrides them; x0 is never tracked.
    always_comb begin
        busy_d = busy;
        if (wb_clr_en) begin
            busy_d[wb_clr_idx] = 1'b0;
        end
        if (fl_clr_en) begin
            busy_d[fl_clr_idx] = 1'b0;
        end
        if (set_en) begin
            busy_d[set_idx] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= '0;
        end else begin
            busy <= busy_d;
        end
    end

    assign raw_busy1 = busy[raw_idx1];
    assign raw_busy2 = busy[raw_idx2];
    assign waw_busy  = busy[waw_idx];

endmodule

// File: rtl/smol_opfetch.sv
// rtl/smol_opfetch.sv - operand fetch: register-file read, writeback bypass, hazard stall, 1-deep output
//   clk, rst : clock, synchronous active-high reset
//   bus      : smol_opfetch_if.slave (in_*, rf_*, wb_*, flush, out_*, stall_cnt)
module smol_opfetch
    import smol_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    smol_opfetch_if.slave bus
);

    logic               raw_busy1;
    logic               raw_busy2;
    logic               waw_busy;
    logic               raw1;
    logic               raw2;
    logic               waw;
    logic               hazard;
    logic               ready;
    logic               accept;
    logic               sb_set_en;
    logic               sb_fl_clr;
    opbundle_t          out_d;
    opbundle_t          out_q;
    logic               out_valid_q;
    logic [STALL_W-1:0] stall_q;

    // Register-file read port follows the decoded fields directly.
    assign bus.rf_raddr1 = bus.in_rs1;
    assign bus.rf_raddr2 = bus.in_rs2;
    assign bus.rf_ren1   = bus.in_valid & bus.in_use_rs1 & (bus.in_rs1 != '0);
    assign bus.rf_ren2   = bus.in_valid & bus.in_use_rs2 & (bus.in_rs2 != '0);

    assign sb_set_en = accept & bus.in_wr_rd & (bus.in_rd != '0);
    assign sb_fl_clr = bus.flush & out_valid_q & out_q.wr_rd;

    smol_scoreboard u_sb (
        .clk        (clk),
        .rst        (rst),
        .set_en     (sb_set_en),
        .set_idx    (bus.in_rd),
        .wb_clr_en  (bus.wb_en),
        .wb_clr_idx (bus.wb_addr),
        .fl_clr_en  (sb_fl_clr),
        .fl_clr_idx (out_q.rd),
        .raw_idx1   (bus.in_rs1),
        .raw_idx2   (bus.in_rs2),
        .raw_busy1  (raw_busy1),
        .raw_busy2  (raw_busy2),
        .waw_idx    (bus.in_rd),
        .waw_busy   (waw_busy)
    );

    // A same-cycle writeback satisfies a RAW through the bypass, but cannot
    // resolve a WAW: the new writer must wait until the old one has retired.
    assign raw1 = bus.in_use_rs1 & (bus.in_rs1 != '0) & raw_busy1
                & !(bus.wb_en & (bus.wb_addr == bus.in_rs1));
    assign raw2 = bus.in_use_rs2 & (bus.in_rs2 != '0) & raw_busy2
                & !(bus.wb_en & (bus.wb_addr == bus.in_rs2));
    assign waw  = bus.in_wr_rd & (bus.in_rd != '0) & waw_busy;

    assign hazard = raw1 | raw2 | waw;
    assign ready  = !rst & !bus.flush & !hazard & (!out_valid_q | bus.out_ready);
    assign accept = bus.in_valid & ready;

    assign bus.in_ready = ready;

    always_comb begin
        out_d.op1   = resolve_operand(bus.in_use_rs1, bus.in_rs1, bus.wb_en,
                                      bus.wb_addr, bus.wb_data, bus.rf_rdata1);
        out_d.op2   = resolve_operand(bus.in_use_rs2, bus.in_rs2, bus.wb_en,
                                      bus.wb_addr, bus.wb_data, bus.rf_rdata2);
        out_d.rd    = bus.in_rd;
        out_d.wr_rd = bus.in_wr_rd;
    end

    // One-entry output register: loads on accept, drains on out_ready,
    // and holds everything while the consumer backpressures.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_q       <= '0;
        end else if (bus.flush) begin
            out_valid_q <= 1'b0;
        end else if (accept) begin
            out_valid_q <= 1'b1;
            out_q       <= out_d;
        end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= '0;
        end else if (bus.in_valid && hazard && !bus.flush && stall_q != '1) begin
            stall_q <= stall_q + STALL_W'(1);
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_op1   = out_q.op1;
    assign bus.out_op2   = out_q.op2;
    assign bus.out_rd    = out_q.rd;
    assign bus.out_wr_rd = out_q.wr_rd;
    assign bus.stall_cnt = stall_q;

endmodule

// File: tb/tb_smol_opfetch.sv
// tb/tb_smol_opfetch.sv - directed table-driven bench for smol_opfetch
module tb_smol_opfetch;
    import smol_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    smol_opfetch_if bus ();

    smol_opfetch dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int checks    = 0;
    int failures  = 0;
    int exp_stall = 0;

    typedef struct {
        logic [4:0]  rs1, rs2, rd;
        logic        u1, u2, wr;
        logic [31:0] d1, d2;
        logic        wbe;
        logic [4:0]  wba;
        logic [31:0] wbd;
        logic        ren1, ren2;
        logic [31:0] op1, op2;
    } vec_t;

    localparam int NV = 10;
    vec_t vecs [NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle();
        bus.in_valid   = 1'b0;
        bus.in_rs1     = '0;
        bus.in_rs2     = '0;
        bus.in_rd      = '0;
        bus.in_use_rs1 = 1'b0;
        bus.in_use_rs2 = 1'b0;
        bus.in_wr_rd   = 1'b0;
        bus.rf_rdata1  = '0;
        bus.rf_rdata2  = '0;
        bus.wb_en      = 1'b0;
        bus.wb_addr    = '0;
        bus.wb_data    = '0;
        bus.flush      = 1'b0;
        bus.out_ready  = 1'b1;
    endtask

    task automatic set_instr(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                             input logic u1, input logic u2, input logic wr,
                             input logic [31:0] d1, input logic [31:0] d2);
        bus.in_valid   = 1'b1;
        bus.in_rs1     = rs1;
        bus.in_rs2     = rs2;
        bus.in_rd      = rd;
        bus.in_use_rs1 = u1;
        bus.in_use_rs2 = u2;
        bus.in_wr_rd   = wr;
        bus.rf_rdata1  = d1;
        bus.rf_rdata2  = d2;
    endtask

    initial begin
        //          rs1 rs2 rd u1 u2 wr d1            d2            wbe wba wbd           ren1 ren2 op1           op2
        vecs[0] = '{3,  4,  0, 1, 1, 0, 32'h11,       32'h22,       0,  0,  32'h0,        1,   1,   32'h11,       32'h22};
        vecs[1] = '{0,  4,  0, 1, 1, 1, 32'hDEAD,     32'h33,       0,  0,  32'h0,        0,   1,   32'h0,        32'h33};
        vecs[2] = '{6,  7,  0, 0, 0, 0, 32'hAAAA,     32'hBBBB,     0,  0,  32'h0,        0,   0,   32'h0,        32'h0};
        vecs[3] = '{8,  9,  0, 1, 1, 0, 32'h5555,     32'h6666,     1,  8,  32'h1234,     1,   1,   32'h1234,     32'h6666};
        vecs[4] = '{10, 10, 0, 1, 1, 0, 32'h1,        32'h2,        1,  10, 32'hBEEF,     1,   1,   32'hBEEF,     32'hBEEF};
        vecs[5] = '{0,  0,  0, 1, 1, 0, 32'h3,        32'h4,        1,  0,  32'hFFFF,     0,   0,   32'h0,        32'h0};
        vecs[6] = '{31, 31, 0, 0, 1, 0, 32'h5,        32'h77,       1,  31, 32'h9999,     0,   1,   32'h0,        32'h9999};
        vecs[7] = '{1,  2,  12,1, 1, 1, 32'h101,      32'h202,      0,  0,  32'h0,        1,   1,   32'h101,      32'h202};
        vecs[8] = '{12, 13, 0, 1, 1, 0, 32'hBAD0,     32'h13,       1,  12, 32'hC0DE,     1,   1,   32'hC0DE,     32'h13};
        vecs[9] = '{12, 0,  12,1, 1, 1, 32'hBAD1,     32'h0,        1,  12, 32'h44,       1,   0,   32'h44,       32'h0};

        // Reset, with a write instruction and a writeback presented at the same time.
        idle();
        set_instr(3, 4, 5, 1, 1, 1, 32'h11, 32'h22);
        bus.wb_en = 1'b1;
        bus.wb_addr = 5'd5;
        @(negedge clk);
        #1;
        check("rst_in_ready", bus.in_ready, 0);
        @(posedge clk);
        #1;
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_op1", bus.out_op1, 0);
        check("rst_out_op2", bus.out_op2, 0);
        check("rst_out_rd", bus.out_rd, 0);
        check("rst_out_wr_rd", bus.out_wr_rd, 0);
        check("rst_stall_cnt", bus.stall_cnt, 0);
        check("rst_busy", dut.u_sb.busy, 0);
        @(negedge clk);
        rst = 1'b0;
        idle();

        // Back-to-back single-cycle vectors.
        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            set_instr(vecs[i].rs1, vecs[i].rs2, vecs[i].rd, vecs[i].u1, vecs[i].u2, vecs[i].wr,
                      vecs[i].d1, vecs[i].d2);
            bus.wb_en   = vecs[i].wbe;
            bus.wb_addr = vecs[i].wba;
            bus.wb_data = vecs[i].wbd;
            #1;
            check($sformatf("v%0d_in_ready", i), bus.in_ready, 1);
            check($sformatf("v%0d_rf_ren1", i), bus.rf_ren1, vecs[i].ren1);
            check($sformatf("v%0d_rf_ren2", i), bus.rf_ren2, vecs[i].ren2);
            check($sformatf("v%0d_rf_raddr1", i), bus.rf_raddr1, vecs[i].rs1);
            check($sformatf("v%0d_rf_raddr2", i), bus.rf_raddr2, vecs[i].rs2);
            @(posedge clk);
            #1;
            check($sformatf("v%0d_out_valid", i), bus.out_valid, 1);
            check($sformatf("v%0d_out_op1", i), bus.out_op1, vecs[i].op1);
            check($sformatf("v%0d_out_op2", i), bus.out_op2, vecs[i].op2);
            check($sformatf("v%0d_out_rd", i), bus.out_rd, vecs[i].rd);
            check($sformatf("v%0d_out_wr_rd", i), bus.out_wr_rd, vecs[i].wr);
        end
        @(negedge clk);
        idle();
        @(posedge clk);
        #1;
        check("drain_out_valid", bus.out_valid, 0);
        check("set_wins_busy", dut.u_sb.busy, 32'h0000_1000);
        check("table_stall_cnt", bus.stall_cnt, 0);

        // Register 12 still busy: a reader stalls; then retire it.
        @(negedge clk);
        set_instr(12, 0, 0, 1, 0, 0, 32'h0, 32'h0);
        #1;
        check("busy12_in_ready", bus.in_ready, 0);
        bus.in_valid = 1'b0;
        bus.wb_en    = 1'b1;
        bus.wb_addr  = 5'd12;
        @(posedge clk);
        #1;
        check("busy12_cleared", dut.u_sb.busy, 0);
        check("busy12_no_stall", bus.stall_cnt, exp_stall);

        // RAW stall resolved by writeback bypass.
        @(negedge clk);
        idle();
        set_instr(0, 0, 5, 0, 0, 1, 32'h0, 32'h0);
        @(posedge clk);
        #1;
        check("raw_busy5_set", dut.u_sb.busy, 32'h0000_0020);
        @(negedge clk);
        set_instr(5, 0, 0, 1, 0, 0, 32'hBAD, 32'h0);
        for (int k = 0; k < 3; k++) begin
            #1;
            check($sformatf("raw_stall%0d_in_ready", k), bus.in_ready, 0);
            @(posedge clk);
            exp_stall++;
            #1;
            check($sformatf("raw_stall%0d_cnt", k), bus.stall_cnt, exp_stall);
            @(negedge clk);
        end
        bus.wb_en   = 1'b1;
        bus.wb_addr = 5'd5;
        bus.wb_data = 32'hCAFE;
        #1;
        check("raw_wb_in_ready", bus.in_ready, 1);
        @(posedge clk);
        #1;
        check("raw_out_valid", bus.out_valid, 1);
        check("raw_out_op1", bus.out_op1, 32'hCAFE);
        check("raw_stall_hold", bus.stall_cnt, exp_stall);
        check("raw_busy_clear", dut.u_sb.busy, 0);

        // WAW: stall persists through the same-cycle writeback, accept next cycle.
        @(negedge clk);
        idle();
        set_instr(0, 0, 7, 0, 0, 1, 32'h0, 32'h0);
        @(posedge clk);
        @(negedge clk);
        #1;
        check("waw_in_ready", bus.in_ready, 0);
        @(posedge clk);
        exp_stall++;
        @(negedge clk);
        bus.wb_en   = 1'b1;
        bus.wb_addr = 5'd7;
        bus.wb_data = 32'h0;
        #1;
        check("waw_wb_in_ready", bus.in_ready, 0);
        @(posedge clk);
        exp_stall++;
        #1;
        check("waw_stall_cnt", bus.stall_cnt, exp_stall);
        @(negedge clk);
        bus.wb_en = 1'b0;
        #1;
        check("waw_after_in_ready", bus.in_ready, 1);
        @(posedge clk);
        #1;
        check("waw_out_valid", bus.out_valid, 1);
        check("waw_out_rd", bus.out_rd, 7);
        check("waw_out_wr_rd", bus.out_wr_rd, 1);
        check("waw_busy7", dut.u_sb.busy, 32'h0000_0080);
        @(negedge clk);
        idle();
        bus.wb_en   = 1'b1;
        bus.wb_addr = 5'd7;
        @(posedge clk);
        #1;
        check("waw_busy_clear", dut.u_sb.busy, 0);

        // Backpressure holds the entry; flush drops it and frees rd 9.
        @(negedge clk);
        idle();
        bus.out_ready = 1'b0;
        set_instr(3, 4, 9, 1, 1, 1, 32'h55, 32'h66);
        #1;
        check("bp_first_in_ready", bus.in_ready, 1);
        @(posedge clk);
        #1;
        check("bp_first_out_valid", bus.out_valid, 1);
        @(negedge clk);
        set_instr(1, 2, 0, 1, 1, 0, 32'h77, 32'h88);
        for (int k = 0; k < 3; k++) begin
            #1;
            check($sformatf("bp%0d_in_ready", k), bus.in_ready, 0);
            @(posedge clk);
            #1;
            check($sformatf("bp%0d_out_valid", k), bus.out_valid, 1);
            check($sformatf("bp%0d_out_op1", k), bus.out_op1, 32'h55);
            check($sformatf("bp%0d_out_op2", k), bus.out_op2, 32'h66);
            check($sformatf("bp%0d_out_rd", k), bus.out_rd, 9);
            @(negedge clk);
            bus.rf_rdata1 = 32'(k);
        end
        check("bp_no_stall_count", bus.stall_cnt, exp_stall);
        bus.flush = 1'b1;
        #1;
        check("flush_in_ready", bus.in_ready, 0);
        @(posedge clk);
        #1;
        check("flush_out_valid", bus.out_valid, 0);
        check("flush_busy9", dut.u_sb.busy, 0);
        check("flush_stall_cnt", bus.stall_cnt, exp_stall);
        @(negedge clk);
        idle();
        set_instr(9, 0, 0, 1, 0, 0, 32'h99, 32'h0);
        #1;
        check("post_flush_rs9_ready", bus.in_ready, 1);
        @(posedge clk);
        #1;
        check("post_flush_op1", bus.out_op1, 32'h99);

        // Fill busy[7:4], stall up to 12, then reset mid-stall.
        for (int r = 4; r < 8; r++) begin
            @(negedge clk);
            idle();
            set_instr(0, 0, 5'(r), 0, 0, 1, 32'h0, 32'h0);
            @(posedge clk);
        end
        #1;
        check("pre_rst_busy", dut.u_sb.busy, 32'h0000_00F0);
        @(negedge clk);
        set_instr(4, 0, 0, 1, 0, 0, 32'h0, 32'h0);
        while (exp_stall < 12) begin
            @(posedge clk);
            exp_stall++;
        end
        #1;
        check("pre_rst_stall_cnt", bus.stall_cnt, 12);
        @(negedge clk);
        rst         = 1'b1;
        bus.wb_en   = 1'b1;
        bus.wb_addr = 5'd4;
        bus.flush   = 1'b1;
        #1;
        check("midrst_in_ready", bus.in_ready, 0);
        @(posedge clk);
        exp_stall = 0;
        #1;
        check("midrst_busy", dut.u_sb.busy, 0);
        check("midrst_stall_cnt", bus.stall_cnt, 0);
        check("midrst_out_valid", bus.out_valid, 0);
        @(negedge clk);
        rst = 1'b0;
        idle();
        set_instr(4, 0, 0, 1, 0, 0, 32'h4444, 32'h0);
        #1;
        check("after_rst_in_ready", bus.in_ready, 1);
        @(posedge clk);
        #1;
        check("after_rst_out_op1", bus.out_op1, 32'h4444);
        check("after_rst_stall_cnt", bus.stall_cnt, exp_stall);
        @(negedge clk);
        idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
